dmem_access_sequencer: RTL and testbench
========================================

Name: dmem_access_sequencer

Overview:
- Sequences the data-memory access of the single-cycle core against a data memory that has variable wait states.
- Sits between the main control decoder / ALU and the data memory.
- Consumes the decoder's active-low memory strobes and drives a req/ack memory port.
- Stalls the PC and register write until the load or store completes, so the rest of the datapath stays single-cycle.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CNT_W, 16, width of the stall-cycle performance counter
TIMEOUT, 255, max cycles in REQ before abort (used only with DMEM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
mem_enable  input  1  active-low, from control; 0 = LW/SW in this instruction
mem_read  input  1  active-low read strobe from control
mem_write  input  1  active-low write strobe from control
alu_addr  input  ADDR_W  effective address from ALU
store_data  input  DATA_W  rt value for SW
mem_req  output  1  request to data memory
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_ack  input  1  memory completion, single-cycle pulse
mem_rdata  input  DATA_W  read data, valid with mem_ack
load_data  output  DATA_W  registered read data to writeback mux
stall  output  1  1 = hold PC, suppress reg_write
bus_err  output  1  timeout flag (DMEM_TIMEOUT_EN only, else tied 0)
stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; load_data=0; bus_err=0; stall_cnt=0.
- States: IDLE, REQ, DONE.
- IDLE:
  - When mem_enable=0, latch alu_addr into mem_addr and store_data into mem_wdata.
  - Set mem_we=1 if mem_write=0, else 0. Write wins if both strobes are low. mem_enable=0 with both strobes high is a read.
  - Go to REQ.
  - stall is combinational: 1 in IDLE when mem_enable=0, so the PC does not advance in the detect cycle.
- REQ:
  - mem_req=1; address, data and we held stable; stall=1.
  - On mem_ack=1: capture mem_rdata into load_data (reads only; writes leave load_data unchanged). Drop mem_req next edge. Go to DONE.
  - Minimum access = 3 cycles (detect, REQ with ack, DONE).
- DONE:
  - stall=0; load_data valid for writeback; PC advances at this edge.
  - Always returns to IDLE, even if mem_enable is still 0. The same instruction is never re-issued.
- mem_ack in IDLE or DONE is ignored.
- stall_cnt: +1 every cycle stall=1. Saturates at all-ones; never wraps.
- Reset mid-access (rst_n=0 in REQ): state returns to IDLE and mem_req=0 at that edge. No DONE and no load_data update occur.
- Input changes on alu_addr/store_data during REQ have no effect.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- When defined:
  - An 8+ bit wait counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT without mem_ack: mem_req drops, load_data=0, bus_err=1 (sticky until reset), go to DONE.
  - mem_ack in the same cycle as the timeout wins: normal completion, no bus_err.
- When undefined: no wait counter. REQ waits indefinitely. bus_err is constant 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with mem_enable=0 and mem_ack=1 -> mem_req=0, stall_cnt=0, state IDLE; stall=1 only from the combinational IDLE term.
- LW, zero-wait: mem_enable=0, mem_read=0, alu_addr=0x0000_0040; mem_ack=1 with mem_rdata=0xDEAD_BEEF in the first REQ cycle -> mem_req high 1 cycle, mem_we=0, load_data=0xDEAD_BEEF in DONE, stall high 2 cycles, stall_cnt=2.
- SW, 4 wait states: store_data=0x1234_5678, addr 0x100, mem_ack on the 5th REQ cycle -> mem_we=1, mem_wdata held at 0x1234_5678 throughout, load_data unchanged, stall high 6 cycles.
- Back-to-back LW/LW at 0x0 and 0x4 -> two distinct requests, DONE->IDLE->REQ, no duplicate request for the first instruction.
- Reset asserted on the 3rd REQ cycle -> next cycle mem_req=0, IDLE, load_data=0; a late mem_ack after reset is ignored.
- DMEM_TIMEOUT_EN with TIMEOUT=8, no ack -> after 8 REQ cycles bus_err=1, load_data=0, DONE, stall released; stall_cnt saturates at 0xFFFF under a long forced stall.

Source files
------------

// File: rtl/dmem_access_sequencer.sv
// Data-memory access sequencer: turns the decoder's active-low strobes into a req/ack access
// and stalls the core until it completes. Define DMEM_TIMEOUT_EN to add a REQ watchdog (bus_err).
module dmem_access_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Any access that is not a write is a read, so the read strobe adds no information.
  logic unused_read_strobe;
  assign unused_read_strobe = mem_read;

  // Combinational so the PC is held in the very cycle the access is detected.
  assign stall = (state == REQ) || ((state == IDLE) && !mem_enable);

`ifdef DMEM_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;

  // wait_cnt holds the number of REQ cycles already spent, so this fires in the TIMEOUT-th one.
  assign timeout_hit = (wait_cnt == WAIT_LAST);
`else
  assign bus_err = 1'b0;
`endif

  // NOTE: reset is synchronous, so rst_n is only looked at inside the clocked block, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      stall_cnt <= '0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (!mem_enable) begin
            mem_addr  <= alu_addr;
            mem_wdata <= store_data;
            mem_we    <= !mem_write;
            mem_req   <= 1'b1;
            state     <= REQ;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              load_data <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (timeout_hit) begin
            mem_req   <= 1'b0;
            load_data <= '0;
            bus_err   <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end

        // The PC advances on this edge; the next instruction starts a fresh detect in IDLE.
        DONE: state <= IDLE;

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Self-checking bench for dmem_access_sequencer: transaction-level reference model,
// per-cycle compare on the falling edge, directed cases plus randomized accesses.
module tb_dmem_access_sequencer;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_enable;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] store_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              bus_err;
  logic [CNT_W-1:0]  stall_cnt;

  dmem_access_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT(TB_TIMEOUT)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_enable(mem_enable),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_addr  (alu_addr),
    .store_data(store_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .load_data (load_data),
    .stall     (stall),
    .bus_err   (bus_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Architectural view of the sequencer: what the memory port and writeback see.
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_load;
  logic              m_we;
  logic              m_err;
  int                m_cnt;

  // Expected outputs for the current cycle, compared on the falling edge.
  logic              exp_valid = 1'b0;
  logic              exp_req;
  logic              exp_stall;
  logic              exp_we;
  logic              exp_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  logic [DATA_W-1:0] exp_load;
  logic [CNT_W-1:0]  exp_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("mem_req",   mem_req,   exp_req);
      check("stall",     stall,     exp_stall);
      check("mem_we",    mem_we,    exp_we);
      check("mem_addr",  mem_addr,  exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
      check("load_data", load_data, exp_load);
      check("stall_cnt", stall_cnt, exp_cnt);
      check("bus_err",   bus_err,   exp_err);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_wdata = '0;
    m_load  = '0;
    m_we    = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  // Publish this cycle's expectations, let the edge happen, then account the stall.
  task automatic run_cycle(input logic req, input logic stl);
    exp_req   = req;
    exp_stall = stl;
    exp_we    = m_we;
    exp_addr  = m_addr;
    exp_wdata = m_wdata;
    exp_load  = m_load;
    exp_err   = m_err;
    exp_cnt   = CNT_W'(m_cnt);
    exp_valid = 1'b1;
    next_cycle();
    if (stl && m_cnt < MAX_CNT) m_cnt++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      mem_enable = 1'b1;
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      alu_addr   = $urandom;
      store_data = $urandom;
      mem_ack    = 1'($urandom);
      mem_rdata  = $urandom;
      run_cycle(1'b0, 1'b0);
    end
  endtask

  // One LW/SW: detect cycle, REQ cycles with ack on REQ cycle waits+1, then DONE.
  // reset_at > 0 pulls rst_n low in that REQ cycle and follows with a late ack.
  task automatic access(input logic is_write, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int waits,
                        input logic [DATA_W-1:0] rdata, input int reset_at);
    int req_len;
    bit timed_out;
    req_len   = waits + 1;
    timed_out = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    if (req_len > TB_TIMEOUT) begin
      req_len   = TB_TIMEOUT;
      timed_out = 1'b1;
    end
`endif
    mem_enable = 1'b0;
    mem_write  = !is_write;
    mem_read   = 1'($urandom);
    alu_addr   = addr;
    store_data = data;
    mem_ack    = 1'($urandom);
    mem_rdata  = $urandom;
    run_cycle(1'b0, 1'b1);
    m_addr  = addr;
    m_wdata = data;
    m_we    = is_write;

    for (int k = 1; k <= req_len; k++) begin
      mem_enable = 1'($urandom);
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      alu_addr   = $urandom;
      store_data = $urandom;
      mem_ack    = !timed_out && (k == req_len);
      mem_rdata  = mem_ack ? rdata : $urandom;
      if (k == reset_at) begin
        rst_n   = 1'b0;
        mem_ack = 1'b0;
      end
      run_cycle(1'b1, 1'b1);
      if (k == reset_at) begin
        rst_n = 1'b1;
        model_reset();
        mem_enable = 1'b1;
        mem_ack    = 1'b1;
        mem_rdata  = $urandom;
        run_cycle(1'b0, 1'b0);
        return;
      end
    end

    if (timed_out) begin
      m_load = '0;
      m_err  = 1'b1;
    end else if (!is_write) begin
      m_load = rdata;
    end
    mem_enable = 1'($urandom);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    mem_ack    = 1'($urandom);
    mem_rdata  = $urandom;
    run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_enable = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    alu_addr   = '0;
    store_data = '0;
    mem_ack    = 1'b1;
    mem_rdata  = '0;
    model_reset();

    // Two reset cycles with a pending access and a stray ack.
    next_cycle();
    check("rst_req",   mem_req,   0);
    check("rst_cnt",   stall_cnt, 0);
    check("rst_stall", stall,     1);
    check("rst_load",  load_data, 0);
    run_cycle(1'b0, 1'b1);
    model_reset();
    rst_n = 1'b1;
    idle_cycles(2);

    // LW, zero wait states.
    access(1'b0, 32'h0000_0040, 32'h0, 0, 32'hDEAD_BEEF, 0);
    check("lw_load", load_data, 32'hDEAD_BEEF);
    check("lw_cnt",  stall_cnt, 2);
    check("lw_we",   mem_we,    0);
    idle_cycles(2);

    // SW, four wait states; load_data must keep the earlier read.
    access(1'b1, 32'h0000_0100, 32'h1234_5678, 4, 32'hFFFF_0000, 0);
    check("sw_load",  load_data, 32'hDEAD_BEEF);
    check("sw_we",    mem_we,    1);
    check("sw_wdata", mem_wdata, 32'h1234_5678);
    check("sw_addr",  mem_addr,  32'h0000_0100);
    check("sw_cnt",   stall_cnt, 8);

    // Back-to-back loads: DONE -> IDLE -> REQ, two separate requests.
    access(1'b0, 32'h0000_0000, $urandom, 1, 32'hA5A5_0001, 0);
    access(1'b0, 32'h0000_0004, $urandom, 0, 32'h5A5A_0002, 0);
    check("b2b_addr", mem_addr,  32'h0000_0004);
    check("b2b_load", load_data, 32'h5A5A_0002);
    check("b2b_cnt",  stall_cnt, 13);

    // Reset in the third REQ cycle, then a late ack that must be ignored.
    access(1'b0, 32'h0000_0080, 32'h0, 6, 32'hBAD0_BAD0, 3);
    check("mrst_req",  mem_req,   0);
    check("mrst_load", load_data, 0);
    check("mrst_cnt",  stall_cnt, 0);
    check("mrst_addr", mem_addr,  0);
    idle_cycles(1);

`ifdef DMEM_TIMEOUT_EN
    access(1'b0, 32'h0000_00C0, 32'h0, 20, 32'h1111_1111, 0);
    check("to_err",  bus_err,   1);
    check("to_load", load_data, 0);
    // Ack in the same cycle as the timeout completes normally.
    access(1'b0, 32'h0000_00C4, 32'h0, TB_TIMEOUT - 1, 32'h2222_2222, 0);
    check("to_ack_load", load_data, 32'h2222_2222);
    idle_cycles(1);
`endif

    for (int t = 0; t < 40; t++) begin
      access(1'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom, 0);
      idle_cycles($urandom_range(0, 3));
    end

    // Long forced stalls until the counter saturates, then one more access.
    while (m_cnt < MAX_CNT) begin
      access(1'($urandom), $urandom, $urandom, 4000, $urandom, 0);
    end
    access(1'b0, 32'h0000_0010, 32'h0, 3, 32'h7777_7777, 0);
    check("sat_cnt", stall_cnt, 16'hFFFF);
    idle_cycles(2);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
